pipe_rca: RTL and testbench
===========================

# pipe_rca

Parametrised, pipelined successor to the team's combinational ripple-carry adder. Operands are split into `STAGES` equal segments, and each segment's ripple chain gets its own register stage, so the carry crosses one segment per clock. The block adds an add/subtract mode, an explicit carry-out and a valid/ready handshake on both sides, and can optionally report signed overflow. It sits in datapaths that need sustained one-result-per-cycle throughput at a clock rate the full-width ripple chain cannot meet.

## Interface
Parameters:
- `WIDTH`, default 16: operand and sum width in bits, ≥ 1.
- `STAGES`, default 4: number of pipeline segments, 1 ≤ `STAGES` ≤ `WIDTH`. `WIDTH % STAGES != 0` is an elaboration error.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input operands present.
- `in_ready`, out, 1: block accepts input this cycle.
- `A`, in, `WIDTH`: operand A.
- `B`, in, `WIDTH`: operand B.
- `Cin`, in, 1: carry-in. Ignored when `Sub`=1.
- `Sub`, in, 1: 0 computes A+B+Cin; 1 computes A−B.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts result.
- `S`, out, `WIDTH`: sum or difference.
- `Cout`, out, 1: carry out of the MSB. Under `Sub`=1, `Cout`=1 means no borrow.
- `V`, out, 1: signed overflow. Exists only with `PIPE_RCA_OVF_EN`.

## Operation
- Segment width is SEG = `WIDTH`/`STAGES`. Stage k (k = 0..`STAGES`−1) ripples bits [k·SEG +: SEG] using the registered carry from stage k−1.
  - Stage 0 carry-in is `Cin`, or 1 when `Sub`=1.
- When `Sub`=1, B is bitwise inverted at the input, before the first register.
- Operand bits for segments not yet processed are carried forward in skew registers. Sum bits already produced are carried forward in de-skew registers.
- Each stage holds a valid bit. The result is delivered only when the last stage's valid bit is set.
- A single global advance enable governs the whole pipeline: en = !`out_valid` || `out_ready`.
  - `in_ready` = en, and is purely combinational from `out_valid`/`out_ready`.
  - When en=1, every stage shifts by one. Stage 0 loads {A, B, Cin, Sub} and valid = `in_valid`.
  - When en=0, every register, including data, holds its value.
- Bubbles are not collapsed. An invalid slot travels through the pipeline like data.
- An input transfer occurs when `in_valid` && `in_ready`. An output transfer occurs when `out_valid` && `out_ready`.
- Each accepted operand set yields exactly one result, in order, with no loss or duplication.
- Widths: internal carry is 1 bit per segment. The full result is {`Cout`, `S`}, which is `WIDTH`+1 bits and exact for unsigned add.

## Timing
- Latency: a result accepted in cycle t appears with `out_valid`=1 in cycle t+`STAGES`, provided no stall occurs.
- With `STAGES`=1 the block reduces to a registered adder with latency 1.
- Throughput: one result per cycle while `out_ready`=1.
- Stall: while `out_valid`=1 and `out_ready`=0, `S`/`Cout`/`V` stay stable, `in_ready`=0, and no input is accepted.
- Reset: in the cycle after `rst`=1 is sampled:
  - all valid bits = 0 and `out_valid` = 0;
  - `S` = 0, `Cout` = 0, `V` = 0;
  - all skew and carry registers = 0.
- Reset takes priority over en and over any handshake in the same cycle.
- Reset mid-operation discards every in-flight operand set; no stale result ever emerges afterwards.
- Input taken while draining: when `out_valid`=1 and `out_ready`=1, a new input is accepted in the same cycle.
- Worst-case combinational path: SEG full-adder cells plus the enable mux.

## Configuration
- `PIPE_RCA_OVF_EN` defined:
  - Port `V` exists.
  - V = carry into MSB XOR carry out of MSB, computed in the last stage and registered alongside `S`.
  - V is valid for both add and subtract.
- `PIPE_RCA_OVF_EN` undefined: port `V` and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use `WIDTH`=16, `STAGES`=4, `out_ready`=1 unless stated otherwise.
- Full carry propagation: A=0xFFFF, B=0x0001, Cin=0, Sub=0 accepted at t0 → at t0+4, `out_valid`=1, `S`=0x0000, `Cout`=1.
- Streaming: 8 back-to-back pairs (A=0x1000·i, B=0x0111·i, Cin=i&1) → 8 consecutive valid results starting 4 cycles after the first, each equal to A+B+Cin, in order.
- Subtract: A=0x0005, B=0x0007, Sub=1, Cin=1 (ignored) → `S`=0xFFFE, `Cout`=0. Then A=0x0007, B=0x0005 → `S`=0x0002, `Cout`=1.
- Backpressure: stream 6 pairs and hold `out_ready`=0 for 3 cycles once `out_valid` rises:
  - `in_ready`=0 during the hold;
  - `S` is held stable;
  - all 6 results are delivered exactly once, in order.
- Reset mid-flight: assert `rst` for 1 cycle with 3 operand sets in flight → next cycle `out_valid`=0, `S`=0, `Cout`=0. No result appears within the following 8 cycles unless new input is given.
- Overflow (with `PIPE_RCA_OVF_EN`):
  - 0x7FFF+0x0001 → `S`=0x8000, `V`=1.
  - 0x8000−0x0001 → `S`=0x7FFF, `V`=1.
  - 0x0003+0x0004 → `V`=0.

Source files
------------

// File: rtl/pipe_rca.sv
// pipe_rca: pipelined ripple-carry adder/subtractor with a valid/ready handshake.
// Operands are cut into STAGES segments of WIDTH/STAGES bits. Each segment's
// ripple chain ends in its own register stage, so the carry crosses one segment
// per clock. Operand bits of later segments travel in skew registers and sum bits
// of earlier segments travel in de-skew registers. One global enable advances
// or holds the whole pipeline.
// Optional feature: define PIPE_RCA_OVF_EN to add the signed-overflow output V.
module pipe_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int unsigned SEG = WIDTH / STAGES;
    localparam int unsigned NST = STAGES;
    localparam int unsigned MSB = WIDTH - 1;

    // Reject configurations that cannot be split into equal segments.
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_rca: WIDTH must be a positive multiple of STAGES");
    end

    // Pipeline state, one entry per stage.
    logic [NST-1:0]            vld_q, vld_d;
    logic [NST-1:0]            cry_q, cry_d;
    logic [NST-1:0][WIDTH-1:0] a_q, a_d;
    logic [NST-1:0][WIDTH-1:0] b_q, b_d;
    logic [NST-1:0][WIDTH-1:0] s_q, s_d;

    // Stage-0 operand conditioning.
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             en;

`ifdef PIPE_RCA_OVF_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] lst_a, lst_b;
`endif

    // Ripple one segment k of a+b starting from carry ci; other sum bits pass through.
    function automatic void seg_add(
        input  logic [WIDTH-1:0] a,
        input  logic [WIDTH-1:0] b,
        input  logic [WIDTH-1:0] s_in,
        input  logic             ci,
        input  int unsigned      k,
        output logic [WIDTH-1:0] s_out,
        output logic             co
    );
        logic c;
        c     = ci;
        s_out = s_in;
        for (int unsigned i = 0; i < SEG; i++) begin
            s_out[k*SEG+i] = a[k*SEG+i] ^ b[k*SEG+i] ^ c;
            c              = (a[k*SEG+i] & b[k*SEG+i]) | (c & (a[k*SEG+i] ^ b[k*SEG+i]));
        end
        co = c;
    endfunction

    // Global advance enable: the pipeline moves unless a result is stuck at the output.
    always_comb begin
        en = !vld_q[NST-1] || out_ready;
    end

    // Operand conditioning: subtraction is A + ~B + 1, Cin ignored.
    always_comb begin
        b_in = Sub ? ~B : B;
        c_in = Sub | Cin;
    end

    // Next-state datapath: every stage ripples its segment from the previous stage's registers.
    always_comb begin
        vld_d = '0;
        cry_d = '0;
        a_d   = '0;
        b_d   = '0;
        s_d   = '0;
`ifdef PIPE_RCA_OVF_EN
        lst_a = A;
        lst_b = b_in;
`endif
        seg_add(A, b_in, '0, c_in, 0, s_d[0], cry_d[0]);
        a_d[0]   = A;
        b_d[0]   = b_in;
        vld_d[0] = in_valid;
        for (int unsigned k = 1; k < NST; k++) begin
            seg_add(a_q[k-1], b_q[k-1], s_q[k-1], cry_q[k-1], k, s_d[k], cry_d[k]);
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            vld_d[k] = vld_q[k-1];
`ifdef PIPE_RCA_OVF_EN
            lst_a    = a_q[k-1];
            lst_b    = b_q[k-1];
`endif
        end
    end

`ifdef PIPE_RCA_OVF_EN
    // Overflow: carry into the MSB (recovered as s^a^b at the MSB) XOR carry out.
    always_comb begin
        ovf_d = s_d[NST-1][MSB] ^ lst_a[MSB] ^ lst_b[MSB] ^ cry_d[NST-1];
    end
`endif

    // Pipeline registers: reset clears everything, otherwise shift when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cry_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
`ifdef PIPE_RCA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (en) begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
`ifdef PIPE_RCA_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    // Output mapping from the last stage.
    always_comb begin
        in_ready  = en;
        out_valid = vld_q[NST-1];
        S         = s_q[NST-1];
        Cout      = cry_q[NST-1];
`ifdef PIPE_RCA_OVF_EN
        V         = ovf_q;
`endif
    end

endmodule

// File: tb/tb_pipe_rca.sv
// Testbench for pipe_rca (WIDTH=16, STAGES=4): directed vector table with exact
// latency checks, streaming, backpressure and reset sequences, then randomized
// traffic checked by a queue-based arithmetic reference model.
module tb_pipe_rca;

    localparam int W  = 16;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Cin = 1'b0;
    logic          Sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  S;
    logic          Cout;
`ifdef PIPE_RCA_OVF_EN
    logic          V;
`endif

    pipe_rca #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout)
`ifdef PIPE_RCA_OVF_EN
        , .V(V)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;

    logic [17:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: {V, Cout, S} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int unsigned r;
        int sa, sb, sr;
        logic [17:0] res;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            r  = 32'(a) + 32'h10000 - 32'(b);
            sr = sa - sb;
        end else begin
            r  = 32'(a) + 32'(b) + 32'(cin);
            sr = sa + sb + int'(cin);
        end
        res[15:0] = r[15:0];
        res[16]   = r[16];
        res[17]   = (sr > 32767) || (sr < -32768);
        return res;
    endfunction

    // Scoreboard: push accepted inputs, pop and compare delivered results, check stall stability.
    logic        stall_prev = 1'b0;
    logic [16:0] held_prev  = '0;
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'({Cout, S}), 32'(held_prev));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'({Cout, S}), 32'(e[16:0]));
`ifdef PIPE_RCA_OVF_EN
                    chk("result_v", 32'(V), 32'(e[17]));
`endif
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(A, B, Cin, Sub));
            stall_prev = out_valid && !out_ready;
            held_prev  = {Cout, S};
        end
    end

    // Drive one operand set and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic ok;
        in_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        cout, v;
    } vec_t;

    vec_t vt[11];

    initial begin
        int base;
        logic [15:0] s_hold;

        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] s_hold;

        vt[0]  = '{"carry_full", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{"sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[2]  = '{"sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[3]  = '{"zero",       16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[4]  = '{"max_cin",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[5]  = '{"plain",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[6]  = '{"sub_zero",   16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{"msb_carry",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[8]  = '{"ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[9]  = '{"ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[10] = '{"no_ovf",     16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_Cout", 32'(Cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_RCA_OVF_EN
        chk("rst_V", 32'(V), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Vector table: one operand set at a time, exact latency of ST cycles.
        for (int i = 0; i < 11; i++) begin
            send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
            in_valid = 1'b0;
            repeat (ST - 2) @(posedge clk);
            @(negedge clk);
            chk({vt[i].name, "_early"}, 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk({vt[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vt[i].name, "_S"}, 32'(S), 32'(vt[i].s));
            chk({vt[i].name, "_Cout"}, 32'(Cout), 32'(vt[i].cout));
`ifdef PIPE_RCA_OVF_EN
            chk({vt[i].name, "_V"}, 32'(V), 32'(vt[i].v));
`endif
            @(posedge clk);
            #1;
        end

        // Streaming: 8 back-to-back pairs give 8 consecutive results after ST cycles.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(32'h1000 * i), 16'(32'h0111 * i), 1'(i & 1), 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (ST) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    chk("stream_consecutive", 32'(out_valid), 32'd1);
                    @(posedge clk);
                end
            end
        join
        drain("stream_drain");
        chk("stream_count", 32'(n_out - base), 32'd8);

        // Backpressure: hold out_ready low for 3 cycles once the first result appears.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
                chk("bp_seen_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                s_hold = S;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_S_stable", 32'(S), 32'(s_hold));
                    if (i < 2) @(posedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_count", 32'(n_out - base), 32'd6);

        // Reset mid-flight with 3 operand sets in the pipe.
        for (int i = 0; i < 3; i++)
            send(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_S", 32'(S), 32'd0);
        chk("midrst_Cout", 32'(Cout), 32'd0);
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("midrst_count", 32'(n_out - base), 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = 16'($urandom);
            B         = 16'($urandom);
            Cin       = 1'($urandom);
            Sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
